l1_ahb_apb_bridge: RTL and testbench
====================================

L1_AHB_APB_BRIDGE -- requirements
Module: l1_ahb_apb_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: APB address width; legal range 3..32.
REQ-002 HCLK  in  1  single clock; all state updates on its rising edge.
REQ-003 HRESET  in  1  reset, synchronous and active-high.
REQ-004 HSEL  in  1  bridge selected; driven by the L1 matrix APB_BRIDGE port.
REQ-005 HADDR  in  32  AHB address.
REQ-006 HTRANS  in  2  AHB transfer type.
REQ-007 HWRITE  in  1  AHB direction.
REQ-008 HSIZE  in  3  AHB size; only byte, halfword and word are legal.
REQ-009 HPROT  in  4  AHB protection.
REQ-010 HWDATA  in  32  AHB write data.
REQ-011 HREADY  in  1  matrix HREADYMUX; marks the end of the previous data phase.
REQ-012 HREADYOUT  out  1  bridge ready; 0 inserts a wait state.
REQ-013 HRESP  out  1  error response.
REQ-014 HRDATA  out  32  registered read data.
REQ-015 PSEL, PENABLE, PWRITE  out  1 each  APB control.
REQ-016 PADDR  out  ADDR_WIDTH  APB address, word aligned.
REQ-017 PWDATA  out  32  APB write data.
REQ-018 PRDATA  in  32; PREADY  in  1; PSLVERR  in  1  APB completer response.
REQ-019 APBACTIVE  out  1  1 whenever state is not IDLE; used for APB clock gating.

Function
REQ-020 Accept a transfer when HSEL=1, HTRANS[1]=1, HREADY=1 and state is IDLE or ERR2.
- On accept, latch HADDR[ADDR_WIDTH-1:0], HWRITE, HSIZE and HPROT.
- HTRANS IDLE or BUSY: no transfer; HREADYOUT=1 and HRESP=0.
REQ-021 States are IDLE, WAIT, SETUP, ACCESS, ERR1 and ERR2.
- Accepted write goes to WAIT; accepted read goes to SETUP.
- WAIT captures HWDATA into PWDATA, then goes to SETUP.
- SETUP goes to ACCESS.
- ACCESS holds while PREADY=0.
- ACCESS with PREADY=1, PSLVERR=0 goes to IDLE.
- ACCESS with PREADY=1, PSLVERR=1 goes to ERR1, then ERR2.
- ERR2 goes to WAIT/SETUP if a transfer is accepted, otherwise to IDLE.
REQ-022 Outputs by state:
- SETUP: PSEL=1, PENABLE=0.
- ACCESS: PSEL=1, PENABLE=1.
- PADDR = {latched addr[ADDR_WIDTH-1:2], 2'b00}; PADDR and PWRITE stable from SETUP through the last ACCESS cycle.
REQ-023 HREADYOUT is 0 in WAIT, SETUP, ACCESS and ERR1, and 1 otherwise. HRESP is 1 in ERR1 and ERR2 only.
REQ-024 Zero-wait-state latency: write = 3 AHB wait states, read = 2 AHB wait states; each PREADY=0 cycle adds exactly 1.
REQ-025 On a read completion (ACCESS with PREADY=1), HRDATA loads PRDATA; it holds otherwise. Completion with PSLVERR=1 also loads HRDATA.
REQ-026 Once PSEL is asserted the APB transfer always completes; HSEL and HTRANS changes mid-transfer are ignored.

Reset
REQ-027 HRESET=1 at a clock edge forces the following on that edge, including mid-transfer (the APB access is abandoned):
- state=IDLE;
- PSEL, PENABLE, PWRITE, HRESP, APBACTIVE = 0;
- PADDR, PWDATA, HRDATA = 0;
- HREADYOUT = 1.

Configuration
REQ-028 Macro L1_APB_BRIDGE_APB4_EN.
- Defined: adds outputs PSTRB[3:0] and PPROT[2:0].
  - PSTRB is decoded from the latched HSIZE and addr[1:0] for writes, and is 4'b0000 for reads.
  - PPROT = {~HPROT[0], 1'b0, HPROT[1]}.
  - Both hold the reset value 0.
- Undefined: these ports and their logic are absent (APB3 behaviour); all other behaviour is identical.

Structure
REQ-029 Package l1_apb_bridge_pkg holds:
- the state enum;
- HTRANS encoding constants;
- the HSIZE/offset-to-PSTRB function.
REQ-030 Single module, no sub-module; the FSM and datapath registers live in one always block set.

Verification
REQ-031 Write 0x0000_0010, HWDATA=0xA5A5_5A5A, PREADY=1 -> PADDR=0x0010, PWDATA=0xA5A5_5A5A; HREADYOUT low for exactly 3 cycles; HRESP=0.
REQ-032 Read 0x0000_0024, PRDATA=0x1234_5678, PREADY low for 2 ACCESS cycles -> 4 wait states; HRDATA=0x1234_5678 with HREADYOUT=1.
REQ-033 Read with PSLVERR=1 -> ERR1 (HRESP=1, HREADYOUT=0), then ERR2 (HRESP=1, HREADYOUT=1); a read issued in ERR2 is accepted and its SETUP follows 1 cycle later.
REQ-034 Byte write to 0x0000_0003 with APB4_EN defined -> PSTRB=4'b1000; halfword write to 0x0000_0002 -> PSTRB=4'b1100; any read -> PSTRB=4'b0000.
REQ-035 HRESET pulsed in ACCESS with PREADY=0 -> next cycle PSEL=0, PENABLE=0, HREADYOUT=1, APBACTIVE=0; the following transfer completes normally.

Source files
------------

// File: rtl/l1_apb_bridge_pkg.sv
// Shared types and helpers for the L1 AHB-to-APB bridge: FSM states,
// AHB transfer/size encodings and the APB4 write-strobe decode.
package l1_apb_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Byte lanes touched by a transfer of the given size at the given word offset.
    function automatic logic [3:0] pstrb_decode(input logic [2:0] size, input logic [1:0] offset);
        logic [3:0] strb;
        case (size)
            HSIZE_BYTE: strb = 4'b0001 << offset;
            HSIZE_HALF: strb = offset[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: strb = 4'b1111;
            default:    strb = 4'b0000;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/l1_ahb_apb_bridge.sv
// AHB-Lite to APB bridge for the L1 matrix APB_BRIDGE port.
// Define L1_APB_BRIDGE_APB4_EN to add the APB4 PSTRB/PPROT outputs.
module l1_ahb_apb_bridge
    import l1_apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]           PWDATA,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
`ifdef L1_APB_BRIDGE_APB4_EN
    output logic [3:0]            PSTRB,
    output logic [2:0]            PPROT,
`endif
    output logic                  APBACTIVE
);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic                    trans_valid;
    logic                    accept;
    logic                    rd_done;
`ifdef L1_APB_BRIDGE_APB4_EN
    logic [3:0]              pstrb_q;
    logic [2:0]              pprot_q;
`endif

    always_comb begin
        trans_valid = 1'b0;
        case (HTRANS)
            HTRANS_IDLE, HTRANS_BUSY: trans_valid = 1'b0;
            HTRANS_NONSEQ, HTRANS_SEQ: trans_valid = 1'b1;
        endcase
    end

    // A new transfer is only taken while no APB access is in flight.
    assign accept  = HSEL && trans_valid && HREADY && (state == ST_IDLE || state == ST_ERR2);
    assign rd_done = (state == ST_ACCESS) && PREADY && !write_q;

    always_comb begin
        state_nxt = state;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        case (state)
            ST_IDLE, ST_ERR2: begin
                HRESP = (state == ST_ERR2);
                if (accept) state_nxt = HWRITE ? ST_WAIT : ST_SETUP;
                else        state_nxt = ST_IDLE;
            end
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                HREADYOUT = 1'b0;
                PSEL      = 1'b1;
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                HREADYOUT = 1'b0;
                PSEL      = 1'b1;
                PENABLE   = 1'b1;
                if (PREADY) state_nxt = PSLVERR ? ST_ERR1 : ST_IDLE;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_nxt = ST_ERR2;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            PWDATA  <= '0;
            HRDATA  <= '0;
`ifdef L1_APB_BRIDGE_APB4_EN
            pstrb_q <= '0;
            pprot_q <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q  <= HADDR[ADDR_WIDTH-1:0];
                write_q <= HWRITE;
`ifdef L1_APB_BRIDGE_APB4_EN
                pstrb_q <= HWRITE ? pstrb_decode(HSIZE, HADDR[1:0]) : 4'b0000;
                pprot_q <= {~HPROT[0], 1'b0, HPROT[1]};
`endif
            end
            // HWDATA is valid in the AHB data phase, which is the WAIT cycle.
            if (state == ST_WAIT) PWDATA <= HWDATA;
            if (rd_done)          HRDATA <= PRDATA;
        end
    end

    assign PADDR     = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign PWRITE    = write_q;
    assign APBACTIVE = (state != ST_IDLE);
`ifdef L1_APB_BRIDGE_APB4_EN
    assign PSTRB     = pstrb_q;
    assign PPROT     = pprot_q;
`endif

    logic unused_ok;
    assign unused_ok = ^{HADDR, HSIZE, HPROT, addr_q[1:0]};

endmodule

// File: tb/tb_l1_ahb_apb_bridge.sv
// Self-checking bench for l1_ahb_apb_bridge: directed scenarios plus randomized
// transfers against a transaction-level model of wait states, addresses and data.
`timescale 1ns/1ps
module tb_l1_ahb_apb_bridge;

    localparam int AW = 16;

    logic          hclk = 1'b0;
    logic          hreset, hsel, hwrite, hready;
    logic [31:0]   haddr, hwdata;
    logic [1:0]    htrans;
    logic [2:0]    hsize;
    logic [3:0]    hprot;
    logic          hreadyout, hresp;
    logic [31:0]   hrdata;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [31:0]   pwdata, prdata;
    logic          pready, pslverr, apbactive;
`ifdef L1_APB_BRIDGE_APB4_EN
    logic [3:0]    pstrb;
    logic [2:0]    pprot;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 hclk = ~hclk;
    assign hready = hreadyout;

    l1_ahb_apb_bridge #(.ADDR_WIDTH(AW)) dut (
        .HCLK(hclk), .HRESET(hreset), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HPROT(hprot), .HWDATA(hwdata), .HREADY(hready),
        .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata),
        .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
`ifdef L1_APB_BRIDGE_APB4_EN
        .PSTRB(pstrb), .PPROT(pprot),
`endif
        .APBACTIVE(apbactive)
    );

    // Behavioural APB completer: PREADY after slv_lows low ACCESS cycles.
    int            slv_lows = 0;
    logic          slv_err = 1'b0;
    logic [31:0]   slv_rdata = '0;
    int            acc_cnt = 0;
    int            done_cnt = 0;
    logic          stab_bad = 1'b0;
    logic [AW-1:0] setup_addr = '0, cap_addr = '0;
    logic          setup_write = 1'b0, cap_write = 1'b0;
    logic [31:0]   cap_wdata = '0;
`ifdef L1_APB_BRIDGE_APB4_EN
    logic [3:0]    cap_strb = '0;
    logic [2:0]    cap_prot = '0;
`endif

    assign pready  = psel && penable && (acc_cnt >= slv_lows);
    assign pslverr = pready && slv_err;
    assign prdata  = slv_rdata;

    always @(posedge hclk) begin
        if (psel === 1'b1 && penable === 1'b0) begin
            setup_addr  <= paddr;
            setup_write <= pwrite;
        end
        if (psel === 1'b1 && penable === 1'b1) begin
            if (paddr !== setup_addr || pwrite !== setup_write) stab_bad <= 1'b1;
        end
        if (psel === 1'b1 && penable === 1'b1 && pready === 1'b0) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (pready === 1'b1) begin
            cap_addr  <= paddr;
            cap_write <= pwrite;
            cap_wdata <= pwdata;
`ifdef L1_APB_BRIDGE_APB4_EN
            cap_strb  <= pstrb;
            cap_prot  <= pprot;
`endif
            done_cnt  <= done_cnt + 1;
        end
    end

    logic [31:0] m_hrdata = '0;

`ifdef L1_APB_BRIDGE_APB4_EN
    function automatic logic [3:0] exp_strb(input logic w, input logic [2:0] sz, input logic [1:0] off);
        int lanes;
        if (!w) return 4'b0000;
        lanes = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
        return 4'(((1 << lanes) - 1) << ((int'(off) / lanes) * lanes));
    endfunction
`endif

    // Issues one AHB transfer starting away from a rising edge and returns what
    // the AHB side observed; it leaves the bench at the negedge where HREADYOUT=1.
    task automatic ahb_xfer(input logic w, input logic [31:0] a, input logic [31:0] wd,
                            input logic [2:0] sz, input logic [3:0] pr,
                            output int waits, output int errc, output logic first_psel,
                            output logic first_pen, output logic end_resp,
                            output logic [31:0] end_rdata, output logic tmo);
        hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = w; hsize = sz; hprot = pr;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = wd; haddr = $urandom; hwrite = 1'($urandom);
        waits = 0; errc = 0; tmo = 1'b1;
        @(negedge hclk);
        first_psel = psel; first_pen = penable;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge hclk);
            if (hreadyout === 1'b1) begin
                tmo = 1'b0;
                break;
            end
            waits++;
            if (hresp === 1'b1) errc++;
        end
        end_resp = hresp; end_rdata = hrdata;
    endtask

    task automatic idle_cycle();
        hsel = 1'b0; htrans = 2'b00;
        @(negedge hclk);
    endtask

    task automatic test_reset();
        hreset = 1'b1; hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0;
        hsize = 3'd2; hprot = 4'd0; hwdata = '0;
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        n_tests++;
        if ({hreadyout, hresp, psel, penable, pwrite, apbactive} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 100000", {hreadyout, hresp, psel, penable, pwrite, apbactive});
        end
        n_tests++;
        if ({paddr, pwdata, hrdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got paddr=%h pwdata=%h hrdata=%h want 0", paddr, pwdata, hrdata);
        end
`ifdef L1_APB_BRIDGE_APB4_EN
        n_tests++;
        if ({pstrb, pprot} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_apb4: got pstrb=%b pprot=%b want 0", pstrb, pprot);
        end
`endif
        m_hrdata = '0;
        hreset = 1'b0;
        @(negedge hclk);
    endtask

    task automatic test_idle_busy();
        logic [2:0] stim [3];
        stim[0] = 3'b101; stim[1] = 3'b100; stim[2] = 3'b010;
        foreach (stim[k]) begin
            hsel = stim[k][2]; htrans = stim[k][1:0]; haddr = $urandom; hwrite = 1'($urandom);
            @(negedge hclk);
            n_tests++;
            if ({hreadyout, hresp, psel, apbactive} !== 4'b1000) begin
                n_fail++;
                $display("FAIL idle_busy_%0d: got %b want 1000", k, {hreadyout, hresp, psel, apbactive});
            end
        end
        idle_cycle();
    endtask

    task automatic test_write_basic();
        int waits, errc; logic fp, fe, er, tmo; logic [31:0] rd;
        slv_lows = 0; slv_err = 1'b0;
        ahb_xfer(1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 3'd2, 4'd1, waits, errc, fp, fe, er, rd, tmo);
        n_tests++;
        if (tmo || waits != 3 || er !== 1'b0 || fp !== 1'b0) begin
            n_fail++;
            $display("FAIL write_basic_timing: got waits=%0d resp=%b wait_psel=%b tmo=%b want waits=3 resp=0 wait_psel=0", waits, er, fp, tmo);
        end
        n_tests++;
        if (cap_addr !== 16'h0010 || cap_wdata !== 32'hA5A5_5A5A || cap_write !== 1'b1) begin
            n_fail++;
            $display("FAIL write_basic_apb: got paddr=%h pwdata=%h pwrite=%b want 0010 a5a55a5a 1", cap_addr, cap_wdata, cap_write);
        end
        idle_cycle();
    endtask

    task automatic test_read_wait();
        int waits, errc; logic fp, fe, er, tmo; logic [31:0] rd;
        slv_lows = 2; slv_err = 1'b0; slv_rdata = 32'h1234_5678;
        ahb_xfer(1'b0, 32'h0000_0024, 32'h0, 3'd2, 4'd0, waits, errc, fp, fe, er, rd, tmo);
        m_hrdata = 32'h1234_5678;
        n_tests++;
        if (tmo || waits != 4 || er !== 1'b0 || fp !== 1'b1 || fe !== 1'b0) begin
            n_fail++;
            $display("FAIL read_wait_timing: got waits=%0d resp=%b setup=%b%b want waits=4 resp=0 setup=10", waits, er, fp, fe);
        end
        n_tests++;
        if (rd !== m_hrdata || cap_addr !== 16'h0024 || cap_write !== 1'b0) begin
            n_fail++;
            $display("FAIL read_wait_data: got hrdata=%h paddr=%h want %h 0024", rd, cap_addr, m_hrdata);
        end
        idle_cycle();
    endtask

    task automatic test_error();
        int waits, errc; logic fp, fe, er, tmo; logic [31:0] rd;
        slv_lows = $urandom_range(0, 2); slv_err = 1'b1; slv_rdata = $urandom;
        ahb_xfer(1'b0, 32'h0000_0040, 32'h0, 3'd2, 4'd0, waits, errc, fp, fe, er, rd, tmo);
        m_hrdata = slv_rdata;
        n_tests++;
        if (tmo || waits != 3 + slv_lows || errc != 1 || er !== 1'b1 || rd !== m_hrdata) begin
            n_fail++;
            $display("FAIL error_resp: got waits=%0d err1=%0d err2_resp=%b hrdata=%h want waits=%0d err1=1 err2_resp=1 hrdata=%h", waits, errc, er, rd, 3 + slv_lows, m_hrdata);
        end
        // Issued directly in the second error cycle.
        slv_lows = 0; slv_err = 1'b0; slv_rdata = $urandom;
        ahb_xfer(1'b0, 32'h0000_0044, 32'h0, 3'd2, 4'd0, waits, errc, fp, fe, er, rd, tmo);
        m_hrdata = slv_rdata;
        n_tests++;
        if (tmo || fp !== 1'b1 || fe !== 1'b0 || waits != 2 || er !== 1'b0 || rd !== m_hrdata || cap_addr !== 16'h0044) begin
            n_fail++;
            $display("FAIL error_followup: got setup=%b%b waits=%0d resp=%b hrdata=%h paddr=%h want setup=10 waits=2 resp=0 hrdata=%h paddr=0044", fp, fe, waits, er, rd, cap_addr, m_hrdata);
        end
        idle_cycle();
    endtask

`ifdef L1_APB_BRIDGE_APB4_EN
    task automatic test_strobe();
        int waits, errc; logic fp, fe, er, tmo; logic [31:0] rd;
        logic [35:0] tbl [3];
        // {write, size, addr[31:0]}
        tbl[0] = {1'b1, 3'd0, 32'h0000_0003};
        tbl[1] = {1'b1, 3'd1, 32'h0000_0002};
        tbl[2] = {1'b0, 3'd2, 32'h0000_0008};
        slv_lows = 0; slv_err = 1'b0;
        foreach (tbl[k]) begin
            ahb_xfer(tbl[k][35], tbl[k][31:0], $urandom, tbl[k][34:32], 4'b0011, waits, errc, fp, fe, er, rd, tmo);
            if (!tbl[k][35]) m_hrdata = slv_rdata;
            n_tests++;
            if (tmo || cap_strb !== exp_strb(tbl[k][35], tbl[k][34:32], tbl[k][1:0]) || cap_prot !== 3'b001) begin
                n_fail++;
                $display("FAIL strobe_%0d: got pstrb=%b pprot=%b want pstrb=%b pprot=001", k, cap_strb, cap_prot, exp_strb(tbl[k][35], tbl[k][34:32], tbl[k][1:0]));
            end
        end
        idle_cycle();
    endtask
`endif

    task automatic test_reset_mid();
        int waits, errc; logic fp, fe, er, tmo; logic [31:0] rd;
        int d0;
        slv_lows = 5; slv_err = 1'b0; slv_rdata = 32'hDEAD_BEEF;
        d0 = done_cnt;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_0030; hwrite = 1'b0; hsize = 3'd2;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00;
        tmo = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge hclk);
            if (psel === 1'b1 && penable === 1'b1) begin
                tmo = 1'b0;
                break;
            end
        end
        hreset = 1'b1;
        @(posedge hclk); #1;
        hreset = 1'b0;
        m_hrdata = '0;
        n_tests++;
        if (tmo || {psel, penable, hreadyout, apbactive, hresp} !== 5'b00100 || hrdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got psel,pen,hrdyout,active,resp=%b hrdata=%h tmo=%b want 00100 0", {psel, penable, hreadyout, apbactive, hresp}, hrdata, tmo);
        end
        @(negedge hclk);
        slv_lows = 0; slv_rdata = 32'h0BAD_F00D;
        ahb_xfer(1'b0, 32'h0000_0034, 32'h0, 3'd2, 4'd0, waits, errc, fp, fe, er, rd, tmo);
        m_hrdata = slv_rdata;
        n_tests++;
        if (tmo || waits != 2 || rd !== m_hrdata || done_cnt != d0 + 1 || cap_addr !== 16'h0034) begin
            n_fail++;
            $display("FAIL reset_mid_recover: got waits=%0d hrdata=%h done=%0d paddr=%h want 2 %h %0d 0034", waits, rd, done_cnt - d0, cap_addr, m_hrdata, 1);
        end
        idle_cycle();
    endtask

    task automatic test_random();
        int waits, errc, d0, exp_w; logic fp, fe, er, tmo; logic [31:0] rd, a, wd;
        logic w; logic [2:0] sz; logic [3:0] pr;
        for (int t = 0; t < 24; t++) begin
            w = 1'($urandom); a = $urandom; wd = $urandom; sz = 3'($urandom_range(0, 2)); pr = 4'($urandom);
            slv_lows = $urandom_range(0, 3); slv_err = ($urandom_range(0, 5) == 0); slv_rdata = $urandom;
            d0 = done_cnt;
            ahb_xfer(w, a, wd, sz, pr, waits, errc, fp, fe, er, rd, tmo);
            if (!w) m_hrdata = slv_rdata;
            exp_w = (w ? 3 : 2) + slv_lows + (slv_err ? 1 : 0);
            n_tests++;
            if (tmo || waits != exp_w || errc != (slv_err ? 1 : 0) || er !== slv_err || fp !== !w) begin
                n_fail++;
                $display("FAIL rand_%0d_timing: got waits=%0d err1=%0d resp=%b first_psel=%b tmo=%b want %0d %0d %b %b", t, waits, errc, er, fp, tmo, exp_w, slv_err ? 1 : 0, slv_err, !w);
            end
            n_tests++;
            if (done_cnt != d0 + 1 || cap_addr !== (a[AW-1:0] & ~16'h3) || cap_write !== w || (w && cap_wdata !== wd) || rd !== m_hrdata) begin
                n_fail++;
                $display("FAIL rand_%0d_data: got paddr=%h pwrite=%b pwdata=%h hrdata=%h want %h %b %h %h", t, cap_addr, cap_write, cap_wdata, rd, a[AW-1:0] & ~16'h3, w, wd, m_hrdata);
            end
`ifdef L1_APB_BRIDGE_APB4_EN
            n_tests++;
            if (cap_strb !== exp_strb(w, sz, a[1:0]) || cap_prot !== {~pr[0], 1'b0, pr[1]}) begin
                n_fail++;
                $display("FAIL rand_%0d_apb4: got pstrb=%b pprot=%b want %b %b", t, cap_strb, cap_prot, exp_strb(w, sz, a[1:0]), {~pr[0], 1'b0, pr[1]});
            end
`endif
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        n_tests++;
        if (stab_bad !== 1'b0) begin
            n_fail++;
            $display("FAIL paddr_stable: got changed=%b want 0", stab_bad);
        end
    endtask

    initial begin
        test_reset();
        test_idle_busy();
        test_write_basic();
        test_read_wait();
        test_error();
`ifdef L1_APB_BRIDGE_APB4_EN
        test_strobe();
`endif
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
